// File: rtl/riscv_trace_pkg.sv
// Shared types for the retirement trace buffer: FSM encodings, word indices, INFO layout, record payload.
// TRACE_TIMESTAMP_EN adds a 32-bit timestamp field and a fourth stream word per record.
package riscv_trace_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned RD_W      = 5;
   localparam int unsigned SEQ_MAX_W = 16;

   localparam int unsigned INFO_RD_LSB  = 0;
   localparam int unsigned INFO_RW_BIT  = 5;
   localparam int unsigned INFO_SEQ_LSB = 16;

   localparam int unsigned WORD_PC   = 0;
   localparam int unsigned WORD_INFO = 1;
   localparam int unsigned WORD_DATA = 2;
   localparam int unsigned WORD_TS   = 3;
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned WORDS_PER_REC = 4;
`else
   localparam int unsigned WORDS_PER_REC = 3;
`endif

   // Each word state is encoded as its word index plus one; zero is idle.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PC   = 3'(WORD_PC + 1),
      ST_INFO = 3'(WORD_INFO + 1),
      ST_DATA = 3'(WORD_DATA + 1),
      ST_TS   = 3'(WORD_TS + 1)
   } trace_state_e;

   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic                 regwrite;
      logic [RD_W-1:0]      rd;
      logic [XLEN-1:0]      data;
      logic [SEQ_MAX_W-1:0] seq;
`ifdef TRACE_TIMESTAMP_EN
      logic [XLEN-1:0]      ts;
`endif
   } trace_rec_t;

   localparam int unsigned REC_W = $bits(trace_rec_t);

   function automatic logic [XLEN-1:0] info_word(input trace_rec_t rec);
      logic [XLEN-1:0] w;
      w = '0;
      w[INFO_RD_LSB +: RD_W]       = rec.rd;
      w[INFO_RW_BIT]               = rec.regwrite;
      w[INFO_SEQ_LSB +: SEQ_MAX_W] = rec.seq;
      return w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered flags/level; a push while full is accepted when a pop occurs the same cycle.
// Exposes the head entry and the entry behind it so a reader can chain records without a bubble.
module trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head_c,
   output logic [WIDTH-1:0]         next_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [LW-1:0]    level_n;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level_n = level + LW'(do_push) - LW'(do_pop);
   assign head_c  = mem[rd_ptr];
   assign next_c  = mem[rd_ptr + AW'(1)];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_n;
         full  <= (level_n == LW'(DEPTH));
         empty <= (level_n == LW'(0));
      end
   end

endmodule

// File: rtl/wb_trace_buffer.sv
// Retirement trace capture: queues {pc, rd, regwrite, data, seq} per retired instruction and streams
// each record as 32-bit words over valid/ready. Define TRACE_TIMESTAMP_EN for a fourth timestamp word.
module wb_trace_buffer
   import riscv_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned SEQ_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic                     wb_valid,
   input  logic [31:0]              wb_pc,
   input  logic                     wb_regwrite,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_data,
   output logic                     tr_valid,
   output logic [31:0]              tr_word,
   output logic                     tr_last,
   input  logic                     tr_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              drop_count,
   output logic                     overflow
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   trace_state_e     state, state_n;
   trace_rec_t       cur, cur_n;
   trace_rec_t       new_rec, head, nxt;
   logic             valid_n, last_n, finish;
   logic [31:0]      word_n;
   logic             attempt, hs, pop, push_ok, drop, full, empty;
   logic [SEQ_W-1:0] seq;

   assign attempt = trace_en && wb_valid;
   assign hs      = tr_valid && tr_ready;
   assign pop     = hs && tr_last;
   assign push_ok = attempt && (!full || pop);
   assign drop    = attempt && full && !pop;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts <= '0;
      else      ts <= ts + 32'd1;
   end
`endif

   always_comb begin
      new_rec          = '0;
      new_rec.pc       = wb_pc;
      new_rec.regwrite = wb_regwrite;
      new_rec.rd       = wb_rd;
      new_rec.data     = wb_data;
      new_rec.seq      = 16'(seq);
`ifdef TRACE_TIMESTAMP_EN
      new_rec.ts       = ts;
`endif
   end

   trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (attempt),
      .pop    (pop),
      .din    (new_rec),
      .head_c (head),
      .next_c (nxt),
      .full   (full),
      .empty  (empty),
      .level  (fifo_level)
   );

   // Serializer: cur holds the record in flight; the FIFO entry is only released on its last word.
   always_comb begin
      state_n = state;
      cur_n   = cur;
      valid_n = tr_valid;
      word_n  = tr_word;
      last_n  = tr_last;
      finish  = 1'b0;
      case (state)
         ST_IDLE: if (!empty) begin
            state_n = ST_PC;
            cur_n   = head;
            valid_n = 1'b1;
            word_n  = head.pc;
            last_n  = 1'b0;
         end
         ST_PC: if (hs) begin
            state_n = ST_INFO;
            word_n  = info_word(cur);
         end
         ST_INFO: if (hs) begin
            state_n = ST_DATA;
            word_n  = cur.data;
`ifdef TRACE_TIMESTAMP_EN
            last_n  = 1'b0;
`else
            last_n  = 1'b1;
`endif
         end
         ST_DATA: if (hs) begin
`ifdef TRACE_TIMESTAMP_EN
            state_n = ST_TS;
            word_n  = cur.ts;
            last_n  = 1'b1;
`else
            finish  = 1'b1;
`endif
         end
`ifdef TRACE_TIMESTAMP_EN
         ST_TS: if (hs) finish = 1'b1;
`endif
         default: state_n = ST_IDLE;
      endcase

      // Chain straight into the next record; a lone queued record arriving this cycle is forwarded.
      if (finish) begin
         if (fifo_level >= LW'(2) || push_ok) begin
            state_n = ST_PC;
            cur_n   = (fifo_level >= LW'(2)) ? nxt : new_rec;
            valid_n = 1'b1;
            word_n  = cur_n.pc;
            last_n  = 1'b0;
         end else begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            word_n  = '0;
            last_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cur      <= '0;
         tr_valid <= 1'b0;
         tr_word  <= '0;
         tr_last  <= 1'b0;
      end else begin
         state    <= state_n;
         cur      <= cur_n;
         tr_valid <= valid_n;
         tr_word  <= word_n;
         tr_last  <= last_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq        <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (attempt) seq <= seq + SEQ_W'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule
